// File: rtl/packetmem_cpu_port_if.sv
// Bus bundle between the packet snooper / BPF CPU side and the packet
// memory responder. The responder uses the slave modport; the side that
// drives writes, reads and accept/reject uses the master modport.
interface packetmem_cpu_port_if #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9
);
  // Snooper write side
  logic                              snoop_wr_en;
  logic [SNOOP_FWD_ADDR_WIDTH-1:0]   snoop_addr;
  logic [63:0]                       snoop_data;
  logic                              snoop_done;
  logic [PACKET_BYTE_ADDR_WIDTH:0]   snoop_len;
  logic                              snoop_ready;
  // CPU read side
  logic                              mem_ready;
  logic [PACKET_BYTE_ADDR_WIDTH:0]   packet_len;
  logic                              packet_mem_rd_en;
  logic [PACKET_BYTE_ADDR_WIDTH-1:0] packet_addr;
  logic [1:0]                        transfer_sz;
  logic [31:0]                       packet_data;
  logic                              cpu_acc;
  logic                              cpu_rej;
  logic                              pkt_accepted;

  modport master (
    output snoop_wr_en, snoop_addr, snoop_data, snoop_done, snoop_len,
    output packet_mem_rd_en, packet_addr, transfer_sz, cpu_acc, cpu_rej,
    input  snoop_ready, mem_ready, packet_len, packet_data, pkt_accepted
  );

  modport slave (
    input  snoop_wr_en, snoop_addr, snoop_data, snoop_done, snoop_len,
    input  packet_mem_rd_en, packet_addr, transfer_sz, cpu_acc, cpu_rej,
    output snoop_ready, mem_ready, packet_len, packet_data, pkt_accepted
  );
endinterface

// File: rtl/packetmem_cpu_port.sv
// Packet memory responder for the BPF CPU read port. Buffers one packet
// as 64-bit words in an even/odd pair of 32-bit banks and serves byte,
// half and word reads at any byte address (big-endian, right-justified,
// zero-extended, 1-cycle latency).
// Optional feature: define PACKETMEM_BOUNDS_CHECK_EN to return 0 for
// reads that extend past the latched packet length.
module packetmem_cpu_port #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9
) (
  input logic                clk,
  input logic                rst,
  packetmem_cpu_port_if.slave bus
);
  localparam int P = PACKET_BYTE_ADDR_WIDTH;
  localparam int S = SNOOP_FWD_ADDR_WIDTH;
  localparam int W = P - 2;

  typedef enum logic [1:0] {EMPTY, FILL, READY, RELEASE} state_t;

  state_t      state_q, state_d;
  logic        acc_q;
  logic [P:0]  packet_len_q;

  logic [31:0] bank_even [0:(1<<S)-1];
  logic [31:0] bank_odd  [0:(1<<S)-1];

  logic        wr_ok, rd_ok, release_now, oob;
  logic [W-1:0] word_idx, word_nxt;
  logic [S-1:0] even_idx, odd_idx;

  logic [31:0] even_p1, odd_p1;
  logic [1:0]  off_p1, sz_p1;
  logic        swap_p1, clr_p1;

  // Picks the addressed bytes out of the two-word window.
  function automatic logic [31:0] align_extract(input logic [63:0] window,
                                                input logic [1:0]  off,
                                                input logic [1:0]  sz);
    logic [63:0] sh;
    sh = window << {off, 3'b000};
    case (sz)
      2'b00:   align_extract = sh[63:32];
      2'b01:   align_extract = {16'h0000, sh[63:48]};
      2'b10:   align_extract = {24'h000000, sh[63:56]};
      default: align_extract = 32'h0000_0000;
    endcase
  endfunction

  assign wr_ok       = bus.snoop_wr_en && (state_q == EMPTY || state_q == FILL);
  assign rd_ok       = bus.packet_mem_rd_en && (state_q == READY) && rst;
  assign release_now = (state_q == READY) && (bus.cpu_acc || bus.cpu_rej);

  // Word w sits in the even bank when w is even; w+1 is the other bank.
  assign word_idx = bus.packet_addr[P-1:2];
  assign word_nxt = word_idx + W'(1);
  assign even_idx = word_nxt[W-1:1];
  assign odd_idx  = word_idx[W-1:1];

`ifdef PACKETMEM_BOUNDS_CHECK_EN
  // Number of bytes a transfer size covers; reserved covers none.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd4;
      2'b01:   size_bytes = 3'd2;
      2'b10:   size_bytes = 3'd1;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  assign oob = ({1'b0, bus.packet_addr} + (P+1)'(size_bytes(bus.transfer_sz)))
               > packet_len_q;
`else
  assign oob = 1'b0;
`endif

  // Bank storage and read-stage data registers (not reset).
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank_even[bus.snoop_addr] <= bus.snoop_data[63:32];
      bank_odd[bus.snoop_addr]  <= bus.snoop_data[31:0];
    end
    if (rd_ok) begin
      even_p1 <= bank_even[even_idx];
      odd_p1  <= bank_odd[odd_idx];
      off_p1  <= bus.packet_addr[1:0];
      sz_p1   <= bus.transfer_sz;
      swap_p1 <= word_idx[0];
    end
  end

  // State register plus control flags that must come out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= EMPTY;
      acc_q        <= 1'b0;
      packet_len_q <= '0;
      clr_p1       <= 1'b1;
    end else begin
      state_q <= state_d;
      if (release_now)
        acc_q <= bus.cpu_acc;
      if (bus.snoop_done && (state_q == EMPTY || state_q == FILL))
        packet_len_q <= bus.snoop_len;
      if (rd_ok)
        clr_p1 <= oob;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (bus.snoop_done)       state_d = READY;
        else if (bus.snoop_wr_en) state_d = FILL;
      end
      FILL:    if (bus.snoop_done) state_d = READY;
      READY:   if (release_now)    state_d = RELEASE;
      RELEASE: state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State-decoded flags.
  always_comb begin
    bus.snoop_ready  = (state_q == EMPTY) || (state_q == FILL);
    bus.mem_ready    = (state_q == READY);
    bus.pkt_accepted = (state_q == RELEASE) && acc_q;
  end

  // ---- stage p1: alignment mux after the registered bank words ----
  assign bus.packet_data = clr_p1 ? 32'h0000_0000
                         : align_extract(swap_p1 ? {odd_p1, even_p1} : {even_p1, odd_p1},
                                         off_p1, sz_p1);
  assign bus.packet_len  = packet_len_q;

endmodule

// File: tb/tb_packetmem_cpu_port.sv
// Directed bench for packetmem_cpu_port: fills a packet, reads it back at
// aligned and unaligned addresses, then exercises release and reset.
module tb_packetmem_cpu_port;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  packetmem_cpu_port_if #(.PACKET_BYTE_ADDR_WIDTH(12), .SNOOP_FWD_ADDR_WIDTH(9)) bus ();

  packetmem_cpu_port #(.PACKET_BYTE_ADDR_WIDTH(12), .SNOOP_FWD_ADDR_WIDTH(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [1:0] sz);
    bus.packet_mem_rd_en = 1'b1;
    bus.packet_addr      = addr;
    bus.transfer_sz      = sz;
    tick();
    bus.packet_mem_rd_en = 1'b0;
  endtask

  initial begin
    bus.snoop_wr_en = 0; bus.snoop_addr = '0; bus.snoop_data = '0;
    bus.snoop_done = 0; bus.snoop_len = '0;
    bus.packet_mem_rd_en = 0; bus.packet_addr = '0; bus.transfer_sz = '0;
    bus.cpu_acc = 0; bus.cpu_rej = 0;

    // Reset state
    tick(); tick();
    rst = 1'b1;
    check("rst_snoop_ready", 32'(bus.snoop_ready), 32'd1);
    check("rst_mem_ready",   32'(bus.mem_ready),   32'd0);
    check("rst_packet_len",  32'(bus.packet_len),  32'd0);
    check("rst_packet_data", bus.packet_data,      32'h0);
    check("rst_pkt_acc",     32'(bus.pkt_accepted), 32'd0);

    // Packet 1: two words, length 16
    bus.snoop_wr_en = 1; bus.snoop_addr = 9'd0; bus.snoop_data = 64'h0011223344556677;
    tick();
    bus.snoop_addr = 9'd1; bus.snoop_data = 64'h8899AABBCCDDEEFF;
    tick();
    bus.snoop_wr_en = 0; bus.snoop_done = 1; bus.snoop_len = 13'd16;
    check("fill_mem_ready_low", 32'(bus.mem_ready), 32'd0);
    tick();
    bus.snoop_done = 0;
    check("p1_mem_ready",   32'(bus.mem_ready),   32'd1);
    check("p1_snoop_ready", 32'(bus.snoop_ready), 32'd0);
    check("p1_packet_len",  32'(bus.packet_len),  32'd16);

    rd(12'd0, 2'b00);  check("word_a0",  bus.packet_data, 32'h00112233);
    rd(12'd6, 2'b00);  check("word_a6",  bus.packet_data, 32'h66778899);
    rd(12'd7, 2'b01);  check("half_a7",  bus.packet_data, 32'h00007788);
    rd(12'd15, 2'b10); check("byte_a15", bus.packet_data, 32'h000000FF);
    rd(12'd0, 2'b11);  check("rsvd_a0",  bus.packet_data, 32'h00000000);

    // Back-to-back word reads
    bus.packet_mem_rd_en = 1; bus.transfer_sz = 2'b00; bus.packet_addr = 12'd1;
    tick();
    check("b2b_a1", bus.packet_data, 32'h11223344);
    bus.packet_addr = 12'd2;
    tick();
    check("b2b_a2", bus.packet_data, 32'h22334455);
    bus.packet_addr = 12'd3;
    tick();
    check("b2b_a3", bus.packet_data, 32'h33445566);
    bus.packet_mem_rd_en = 0;
    tick();
    check("hold_after_b2b", bus.packet_data, 32'h33445566);

    // Snoop write in READY is ignored
    bus.snoop_wr_en = 1; bus.snoop_addr = 9'd0; bus.snoop_data = 64'hDEADBEEFCAFEF00D;
    tick();
    bus.snoop_wr_en = 0;
    rd(12'd0, 2'b00);  check("ready_write_ignored", bus.packet_data, 32'h00112233);

    // Accept and reject together: accept wins
    bus.cpu_acc = 1; bus.cpu_rej = 1;
    tick();
    bus.cpu_acc = 0; bus.cpu_rej = 0;
    check("acc_mem_ready_fall", 32'(bus.mem_ready),    32'd0);
    check("acc_pulse",          32'(bus.pkt_accepted), 32'd1);
    check("acc_snoop_ready_lo", 32'(bus.snoop_ready),  32'd0);
    bus.packet_mem_rd_en = 1; bus.packet_addr = 12'd6; bus.transfer_sz = 2'b00;
    tick();
    bus.packet_mem_rd_en = 0;
    check("acc_pulse_end",      32'(bus.pkt_accepted), 32'd0);
    check("acc_snoop_ready",    32'(bus.snoop_ready),  32'd1);
    tick();
    check("read_in_empty_hold", bus.packet_data, 32'h00112233);

    // Packet 2: rewrite word 1, length 14
    bus.snoop_wr_en = 1; bus.snoop_addr = 9'd1; bus.snoop_data = 64'h8899AABBCCDDEEFF;
    tick();
    bus.snoop_wr_en = 0; bus.snoop_done = 1; bus.snoop_len = 13'd14;
    tick();
    bus.snoop_done = 0;
    check("p2_packet_len", 32'(bus.packet_len), 32'd14);
    rd(12'd12, 2'b00);
`ifdef PACKETMEM_BOUNDS_CHECK_EN
    check("word_a12_len14", bus.packet_data, 32'h00000000);
`else
    check("word_a12_len14", bus.packet_data, 32'hCCDDEEFF);
`endif
    rd(12'd12, 2'b01); check("half_a12_len14", bus.packet_data, 32'h0000CCDD);

    // Reject only: no accept pulse
    bus.cpu_rej = 1;
    tick();
    bus.cpu_rej = 0;
    check("rej_mem_ready", 32'(bus.mem_ready),    32'd0);
    check("rej_no_pulse",  32'(bus.pkt_accepted), 32'd0);
    tick();

    // Packet 3: write and done in the same cycle
    bus.snoop_wr_en = 1; bus.snoop_addr = 9'd2; bus.snoop_data = 64'h0102030405060708;
    bus.snoop_done = 1; bus.snoop_len = 13'd24;
    tick();
    bus.snoop_wr_en = 0; bus.snoop_done = 0;
    check("p3_mem_ready", 32'(bus.mem_ready), 32'd1);
    rd(12'd16, 2'b00); check("word_a16", bus.packet_data, 32'h01020304);

    // Reset in READY drops a read issued in the same cycle
    rst = 0;
    bus.packet_mem_rd_en = 1; bus.packet_addr = 12'd20; bus.transfer_sz = 2'b00;
    tick();
    rst = 1;
    bus.packet_mem_rd_en = 0;
    check("rstrdy_mem_ready",   32'(bus.mem_ready),   32'd0);
    check("rstrdy_packet_len",  32'(bus.packet_len),  32'd0);
    check("rstrdy_packet_data", bus.packet_data,      32'h0);
    check("rstrdy_snoop_ready", 32'(bus.snoop_ready), 32'd1);
    tick();
    check("rstrdy_read_dropped", bus.packet_data, 32'h0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule
